// File: rtl/ls_queue_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ls_queue_pkg                                            |
// | Brief    : Shared op codes, memory access types and FSM states     |
// |            for the load/store queue.                               |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
package ls_queue_pkg;

  // Load/store op codes shared with the dispatch stage
  localparam logic [4:0] OP_LB  = 5'd1;
  localparam logic [4:0] OP_LH  = 5'd2;
  localparam logic [4:0] OP_LW  = 5'd3;
  localparam logic [4:0] OP_LBU = 5'd4;
  localparam logic [4:0] OP_LHU = 5'd5;
  localparam logic [4:0] OP_SB  = 5'd6;
  localparam logic [4:0] OP_SH  = 5'd7;
  localparam logic [4:0] OP_SW  = 5'd8;

  // Memory controller access-type encoding
  localparam logic [2:0] MT_LB      = 3'b110;
  localparam logic [2:0] MT_LBU     = 3'b010;
  localparam logic [2:0] MT_LH      = 3'b101;
  localparam logic [2:0] MT_LHU     = 3'b001;
  localparam logic [2:0] MT_WORD    = 3'b000;
  localparam logic [2:0] MT_SB      = 3'b010;
  localparam logic [2:0] MT_SH      = 3'b001;
  localparam logic [2:0] MT_INVALID = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } lsq_state_t;

  // Effective address: base plus immediate, wrapping modulo 2^32
  function automatic logic [31:0] eff_addr(input logic [31:0] base,
                                           input logic [31:0] offset);
    return base + offset;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ls_type_decode.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ls_type_decode                                          |
// | Brief    : Combinational op decode into load/store class and       |
// |            memory access type.                                     |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module ls_type_decode
  import ls_queue_pkg::*;
(
  input  logic [4:0] op,
  output logic       is_load,
  output logic       is_store,
  output logic [2:0] mem_type
);

  // Classify op; anything that is not a load or store reads as invalid
  always_comb begin
    is_load  = 1'b0;
    is_store = 1'b0;
    mem_type = MT_INVALID;
    case (op)
      OP_LB:   begin is_load  = 1'b1; mem_type = MT_LB;   end
      OP_LBU:  begin is_load  = 1'b1; mem_type = MT_LBU;  end
      OP_LH:   begin is_load  = 1'b1; mem_type = MT_LH;   end
      OP_LHU:  begin is_load  = 1'b1; mem_type = MT_LHU;  end
      OP_LW:   begin is_load  = 1'b1; mem_type = MT_WORD; end
      OP_SB:   begin is_store = 1'b1; mem_type = MT_SB;   end
      OP_SH:   begin is_store = 1'b1; mem_type = MT_SH;   end
      OP_SW:   begin is_store = 1'b1; mem_type = MT_WORD; end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ls_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : ls_queue                                                |
// | Brief    : In-order load/store queue with CDB snooping, commit-    |
// |            gated stores, mispredict flush and occupancy output.    |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module ls_queue
  import ls_queue_pkg::*;
#(
  parameter int               DEPTH    = 16,
  parameter int               TAG_W    = 4,
  parameter logic [TAG_W-1:0] NONE_TAG = {TAG_W{1'b1}}
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic                    rdy_in,
  input  logic                    disp_valid,
  input  logic [4:0]              disp_op,
  input  logic [TAG_W-1:0]        disp_tag,
  input  logic [31:0]             disp_imm,
  input  logic [31:0]             disp_vj,
  input  logic [31:0]             disp_vk,
  input  logic [TAG_W-1:0]        disp_qj,
  input  logic [TAG_W-1:0]        disp_qk,
  output logic                    disp_ready,
  output logic [$clog2(DEPTH):0]  count,
  input  logic                    cdb_active,
  input  logic [TAG_W-1:0]        cdb_tag,
  input  logic [31:0]             cdb_val,
  input  logic                    commit_valid,
  input  logic [TAG_W-1:0]        commit_tag,
  input  logic                    flush,
  output logic                    mem_valid,
  output logic                    mem_r_nw,
  output logic [2:0]              mem_type,
  output logic [31:0]             mem_addr,
  output logic [31:0]             mem_wdata,
  input  logic                    mem_done,
  input  logic [31:0]             mem_rdata,
  output logic                    submit_valid,
  output logic [TAG_W-1:0]        submit_tag,
  output logic [31:0]             submit_val
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int PTR_W = IDX_W + 1;

  // Pointers carry one extra wrap bit so every slot is usable
  logic [PTR_W-1:0] front, rear;
  logic [IDX_W-1:0] fi, ri;
  logic             empty, full;

  logic [4:0]       e_op  [DEPTH];
  logic [TAG_W-1:0] e_tag [DEPTH];
  logic [TAG_W-1:0] e_qj  [DEPTH];
  logic [TAG_W-1:0] e_qk  [DEPTH];
  logic [31:0]      e_imm [DEPTH];
  logic [31:0]      e_vj  [DEPTH];
  logic [31:0]      e_vk  [DEPTH];
  logic [DEPTH-1:0] e_st, e_cm, in_q;

  assign fi         = front[IDX_W-1:0];
  assign ri         = rear[IDX_W-1:0];
  assign count      = rear - front;
  assign empty      = (rear == front);
  assign full       = (rear[IDX_W] != front[IDX_W]) && (ri == fi);
  assign disp_ready = !full;

  // An entry is live when its distance from the head is below occupancy
  for (genvar i = 0; i < DEPTH; i++) begin : g_inq
    assign in_q[i] = ({1'b0, IDX_W'(i) - fi} < count);
  end

  // Dispatch decode and operand bypass from a same-cycle CDB broadcast
  logic       disp_ld, disp_st;
  logic [2:0] disp_mt;
  ls_type_decode u_disp_dec (
    .op       (disp_op),
    .is_load  (disp_ld),
    .is_store (disp_st),
    .mem_type (disp_mt)
  );

  logic             do_push, hit_j, hit_k;
  logic [31:0]      push_vj, push_vk;
  logic [TAG_W-1:0] push_qj, push_qk;
  assign do_push = rdy_in && !flush && disp_valid && disp_ready && (disp_mt != MT_INVALID);
  assign hit_j   = cdb_active && (disp_qj != NONE_TAG) && (disp_qj == cdb_tag);
  assign hit_k   = cdb_active && !disp_ld && (disp_qk != NONE_TAG) && (disp_qk == cdb_tag);
  assign push_vj = hit_j ? cdb_val : disp_vj;
  assign push_qj = hit_j ? NONE_TAG : disp_qj;
  assign push_vk = hit_k ? cdb_val : disp_vk;
  assign push_qk = (disp_ld || hit_k) ? NONE_TAG : disp_qk;

  // Head decode drives issue eligibility and the request access type
  logic       head_ld, head_st, head_ready;
  logic [2:0] head_mt;
  ls_type_decode u_head_dec (
    .op       (e_op[fi]),
    .is_load  (head_ld),
    .is_store (head_st),
    .mem_type (head_mt)
  );
  assign head_ready = !empty && !flush && (e_qj[fi] == NONE_TAG) && (e_qk[fi] == NONE_TAG)
                      && (head_ld || (head_st && e_cm[fi]));

  // Length of the committed-store run at the head; those entries survive a flush
  logic [PTR_W-1:0] run;
  logic             run_on;
  logic [IDX_W-1:0] scan;
  always_comb begin
    run    = '0;
    run_on = 1'b1;
    scan   = fi;
    for (int k = 0; k < DEPTH; k++) begin
      scan = fi + IDX_W'(k);
      if (run_on && (PTR_W'(k) < count) && e_st[scan] && e_cm[scan]) run = run + PTR_W'(1);
      else run_on = 1'b0;
    end
  end

  // Issue/complete FSM: next state and control strobes
  lsq_state_t state_q, state_d;
  logic       issue, complete;
  always_comb begin
    state_d  = state_q;
    issue    = 1'b0;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: if (head_ready) begin issue = 1'b1; state_d = ST_WAIT; end
      ST_WAIT: if (mem_done) begin complete = 1'b1; state_d = ST_IDLE; end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else if (rdy_in) state_q <= state_d;
  end

  // A load squashed by a flush still completes but neither pops nor submits
  logic             fl_load, fl_kill;
  logic [TAG_W-1:0] fl_tag;
  logic             drop_done, pop;
  assign drop_done = fl_load && (fl_kill || flush);
  assign pop       = complete && !drop_done;

  // Entry storage: snoop, commit, push and pointer movement
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      front <= '0;
      rear  <= '0;
      e_st  <= '0;
      e_cm  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_op[i]  <= '0;
        e_tag[i] <= '0;
        e_imm[i] <= '0;
        e_vj[i]  <= '0;
        e_vk[i]  <= '0;
        e_qj[i]  <= NONE_TAG;
        e_qk[i]  <= NONE_TAG;
      end
    end else if (rdy_in) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (in_q[i]) begin
          if (cdb_active && (e_qj[i] != NONE_TAG) && (e_qj[i] == cdb_tag)) begin
            e_vj[i] <= cdb_val;
            e_qj[i] <= NONE_TAG;
          end
          if (cdb_active && (e_qk[i] != NONE_TAG) && (e_qk[i] == cdb_tag)) begin
            e_vk[i] <= cdb_val;
            e_qk[i] <= NONE_TAG;
          end
          if (commit_valid && e_st[i] && (e_tag[i] == commit_tag)) e_cm[i] <= 1'b1;
        end
      end
      if (do_push) begin
        e_op[ri]  <= disp_op;
        e_tag[ri] <= disp_tag;
        e_imm[ri] <= disp_imm;
        e_vj[ri]  <= push_vj;
        e_vk[ri]  <= push_vk;
        e_qj[ri]  <= push_qj;
        e_qk[ri]  <= push_qk;
        e_st[ri]  <= disp_st;
        e_cm[ri]  <= 1'b0;
      end
      if (flush) rear <= front + run;
      else if (do_push) rear <= rear + PTR_W'(1);
      if (pop) front <= front + PTR_W'(1);
    end
  end

  // Memory request, in-flight bookkeeping and load result registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_valid    <= 1'b0;
      mem_r_nw     <= 1'b0;
      mem_type     <= '0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      submit_valid <= 1'b0;
      submit_tag   <= '0;
      submit_val   <= '0;
      fl_load      <= 1'b0;
      fl_kill      <= 1'b0;
      fl_tag       <= '0;
    end else if (rdy_in) begin
      mem_valid    <= 1'b0;
      submit_valid <= 1'b0;
      if (issue) begin
        mem_valid <= 1'b1;
        mem_r_nw  <= head_ld;
        mem_type  <= head_mt;
        mem_addr  <= eff_addr(e_vj[fi], e_imm[fi]);
        mem_wdata <= e_vk[fi];
        fl_load   <= head_ld;
        fl_tag    <= e_tag[fi];
        fl_kill   <= 1'b0;
      end
      if ((state_q == ST_WAIT) && flush && fl_load) fl_kill <= 1'b1;
      if (complete && fl_load && !drop_done) begin
        submit_valid <= 1'b1;
        submit_tag   <= fl_tag;
        submit_val   <= mem_rdata;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ls_queue.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module   : tb_ls_queue                                             |
// | Brief    : Directed self-checking bench for ls_queue (DEPTH=4).    |
// | Revision : 1.0  initial release                                    |
// +--------------------------------------------------------------------+
module tb_ls_queue;
  import ls_queue_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in, rdy_in;
  logic        disp_valid;
  logic [4:0]  disp_op;
  logic [3:0]  disp_tag, disp_qj, disp_qk;
  logic [31:0] disp_imm, disp_vj, disp_vk;
  logic        disp_ready;
  logic [2:0]  count;
  logic        cdb_active;
  logic [3:0]  cdb_tag;
  logic [31:0] cdb_val;
  logic        commit_valid;
  logic [3:0]  commit_tag;
  logic        flush;
  logic        mem_valid, mem_r_nw;
  logic [2:0]  mem_type;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_done;
  logic [31:0] mem_rdata;
  logic        submit_valid;
  logic [3:0]  submit_tag;
  logic [31:0] submit_val;

  int errors = 0;
  int checks = 0;

  ls_queue #(.DEPTH(4), .TAG_W(4), .NONE_TAG(4'hF)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
    .disp_valid(disp_valid), .disp_op(disp_op), .disp_tag(disp_tag), .disp_imm(disp_imm),
    .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_qj(disp_qj), .disp_qk(disp_qk),
    .disp_ready(disp_ready), .count(count),
    .cdb_active(cdb_active), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
    .commit_valid(commit_valid), .commit_tag(commit_tag), .flush(flush),
    .mem_valid(mem_valid), .mem_r_nw(mem_r_nw), .mem_type(mem_type),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done), .mem_rdata(mem_rdata),
    .submit_valid(submit_valid), .submit_tag(submit_tag), .submit_val(submit_val)
  );

  always #5 clk_in = ~clk_in;

  // Advance one clock and settle just after the edge
  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle_in;
    disp_valid   = 1'b0;
    cdb_active   = 1'b0;
    commit_valid = 1'b0;
    flush        = 1'b0;
    mem_done     = 1'b0;
  endtask

  task automatic disp(input logic [4:0] op, input logic [3:0] tag, input logic [31:0] vj,
                      input logic [31:0] imm, input logic [31:0] vk,
                      input logic [3:0] qj, input logic [3:0] qk);
    disp_valid = 1'b1;
    disp_op    = op;
    disp_tag   = tag;
    disp_vj    = vj;
    disp_imm   = imm;
    disp_vk    = vk;
    disp_qj    = qj;
    disp_qk    = qk;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", name, got, exp);
    end
  endtask

  initial begin
    rst_in = 1'b1; rdy_in = 1'b1;
    idle_in();
    disp_op = '0; disp_tag = '0; disp_imm = '0; disp_vj = '0; disp_vk = '0;
    disp_qj = 4'hF; disp_qk = 4'hF;
    cdb_tag = '0; cdb_val = '0; commit_tag = '0; mem_rdata = '0;
    tick(); tick();
    rst_in = 1'b0;

    // Reset state
    chk("rst_count", 32'(count), 0);
    chk("rst_ready", 32'(disp_ready), 1);
    chk("rst_mem_valid", 32'(mem_valid), 0);
    chk("rst_submit", 32'(submit_valid), 0);
    chk("rst_addr", mem_addr, 0);

    // Non load/store op is not queued
    disp(5'd0, 4'd1, 32'h0, 32'h0, 32'h0, 4'hF, 4'hF);
    tick(); idle_in();
    chk("bad_op_count", 32'(count), 0);

    // Ready LW: issue one cycle after push, result one cycle after done
    disp(OP_LW, 4'd5, 32'h100, 32'h4, 32'h0, 4'hF, 4'hF);
    tick(); idle_in();
    chk("lw_count", 32'(count), 1);
    chk("lw_no_early", 32'(mem_valid), 0);
    tick();
    chk("lw_mem_valid", 32'(mem_valid), 1);
    chk("lw_addr", mem_addr, 32'h104);
    chk("lw_rnw", 32'(mem_r_nw), 1);
    chk("lw_type", 32'(mem_type), 32'(MT_WORD));
    mem_done = 1'b1; mem_rdata = 32'hDEADBEEF;
    tick(); idle_in();
    chk("lw_pulse", 32'(mem_valid), 0);
    chk("lw_submit", 32'(submit_valid), 1);
    chk("lw_sub_tag", 32'(submit_tag), 5);
    chk("lw_sub_val", submit_val, 32'hDEADBEEF);
    chk("lw_pop", 32'(count), 0);
    tick();
    chk("lw_sub_pulse", 32'(submit_valid), 0);

    // SW waiting on qk, then on commit
    disp(OP_SW, 4'd6, 32'h200, 32'h8, 32'h0, 4'hF, 4'd3);
    tick(); idle_in(); tick();
    chk("sw_wait_op", 32'(mem_valid), 0);
    cdb_active = 1'b1; cdb_tag = 4'd3; cdb_val = 32'h55;
    tick(); idle_in(); tick();
    chk("sw_uncommitted", 32'(mem_valid), 0);
    commit_valid = 1'b1; commit_tag = 4'd6;
    tick(); idle_in();
    chk("sw_commit_edge", 32'(mem_valid), 0);
    tick();
    chk("sw_issue", 32'(mem_valid), 1);
    chk("sw_rnw", 32'(mem_r_nw), 0);
    chk("sw_wdata", mem_wdata, 32'h55);
    chk("sw_addr", mem_addr, 32'h208);
    mem_done = 1'b1;
    tick(); idle_in();
    chk("sw_no_submit", 32'(submit_valid), 0);
    chk("sw_pop", 32'(count), 0);

    // Fill, refused push while popping when full, then wrap
    for (int t = 1; t <= 4; t++) begin
      disp(OP_SW, 4'(t), 32'(t * 32'h40), 32'h0, 32'h0, 4'hF, 4'hF);
      tick();
    end
    idle_in();
    chk("full_count", 32'(count), 4);
    chk("full_ready", 32'(disp_ready), 0);
    commit_valid = 1'b1; commit_tag = 4'd1;
    tick(); idle_in(); tick();
    chk("sw1_addr", mem_addr, 32'h40);
    mem_done = 1'b1;
    disp(OP_LW, 4'd9, 32'h300, 32'h0, 32'h0, 4'hF, 4'hF);
    tick();
    mem_done = 1'b0;
    chk("refused_count", 32'(count), 3);
    chk("refused_ready", 32'(disp_ready), 1);
    tick(); idle_in();
    chk("wrap_count", 32'(count), 4);
    chk("wrap_ready", 32'(disp_ready), 0);
    commit_valid = 1'b1; commit_tag = 4'd2;
    tick(); idle_in(); tick();
    chk("sw2_addr", mem_addr, 32'h80);
    mem_done = 1'b1; commit_valid = 1'b1; commit_tag = 4'd3;
    tick(); idle_in(); tick();
    chk("sw3_addr", mem_addr, 32'hC0);
    mem_done = 1'b1; commit_valid = 1'b1; commit_tag = 4'd4;
    tick(); idle_in(); tick();
    chk("sw4_addr", mem_addr, 32'h100);
    mem_done = 1'b1;
    tick(); idle_in(); tick();
    chk("lw9_issue", 32'(mem_valid), 1);
    chk("lw9_addr", mem_addr, 32'h300);
    mem_done = 1'b1; mem_rdata = 32'h1234;
    tick(); idle_in();
    chk("lw9_tag", 32'(submit_tag), 9);
    chk("lw9_val", submit_val, 32'h1234);
    chk("drain_count", 32'(count), 0);

    // Dispatch bypass of qj from a same-cycle broadcast
    disp(OP_LW, 4'd2, 32'h0, 32'h10, 32'h0, 4'd7, 4'hF);
    cdb_active = 1'b1; cdb_tag = 4'd7; cdb_val = 32'h20;
    tick(); idle_in(); tick();
    chk("byp_issue", 32'(mem_valid), 1);
    chk("byp_addr", mem_addr, 32'h30);
    mem_done = 1'b1; mem_rdata = 32'h77;
    tick(); idle_in();
    chk("byp_submit", 32'(submit_valid), 1);
    chk("byp_val", submit_val, 32'h77);

    // Flush with a load in flight after a committed store has drained
    disp(OP_SW, 4'd1, 32'h500, 32'h0, 32'hAB, 4'hF, 4'hF);
    tick();
    disp(OP_LW, 4'd2, 32'h600, 32'h0, 32'h0, 4'hF, 4'hF);
    tick();
    disp(OP_LB, 4'd3, 32'h700, 32'h0, 32'h0, 4'hF, 4'hF);
    commit_valid = 1'b1; commit_tag = 4'd1;
    tick(); idle_in(); tick();
    chk("fl_sw_addr", mem_addr, 32'h500);
    chk("fl_sw_wdata", mem_wdata, 32'hAB);
    mem_done = 1'b1;
    tick(); idle_in();
    chk("fl_pre_count", 32'(count), 2);
    tick();
    chk("fl_lw_addr", mem_addr, 32'h600);
    flush = 1'b1;
    disp(OP_LW, 4'd8, 32'h0, 32'h0, 32'h0, 4'hF, 4'hF);
    tick(); idle_in();
    chk("fl_count", 32'(count), 0);
    tick();
    mem_done = 1'b1; mem_rdata = 32'hAAAA;
    tick(); idle_in();
    chk("fl_no_submit", 32'(submit_valid), 0);
    chk("fl_post_count", 32'(count), 0);
    disp(OP_LW, 4'd4, 32'h800, 32'h0, 32'h0, 4'hF, 4'hF);
    tick(); idle_in(); tick();
    chk("fl_next_addr", mem_addr, 32'h800);
    mem_done = 1'b1; mem_rdata = 32'hBEEF;
    tick(); idle_in();
    chk("fl_next_tag", 32'(submit_tag), 4);
    chk("fl_next_val", submit_val, 32'hBEEF);

    // rdy_in low freezes a pending request
    disp(OP_LW, 4'd6, 32'h900, 32'h0, 32'h0, 4'hF, 4'hF);
    tick(); idle_in(); tick();
    chk("frz_issue", 32'(mem_valid), 1);
    rdy_in = 1'b0;
    tick(); tick(); tick();
    chk("frz_hold_mv", 32'(mem_valid), 1);
    chk("frz_count", 32'(count), 1);
    rdy_in = 1'b1; mem_done = 1'b1; mem_rdata = 32'h99;
    tick(); idle_in();
    chk("frz_submit", 32'(submit_valid), 1);
    chk("frz_val", submit_val, 32'h99);

    // Reset mid-WAIT; a stray completion is ignored
    disp(OP_LW, 4'd7, 32'hA00, 32'h0, 32'h0, 4'hF, 4'hF);
    tick(); idle_in(); tick();
    chk("rw_issue", 32'(mem_valid), 1);
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk("rw_count", 32'(count), 0);
    chk("rw_mem_valid", 32'(mem_valid), 0);
    mem_done = 1'b1; mem_rdata = 32'h5;
    tick(); idle_in();
    chk("rw_stray", 32'(submit_valid), 0);
    chk("rw_stray_count", 32'(count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
